// File: rtl/spike_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder_if
// Brief    : Pixel-load and AER-output signal bundle of the spike encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface spike_encoder_if #(
    parameter int M = 8,
    parameter int P = 8
);
    logic         NEW_IMAGE;
    logic [P-1:0] PIXEL_DATA;
    logic         PIXEL_VALID;
    logic         PIXEL_READY;
    logic         INFERENCE_RDY;
    logic [M-1:0] AERIN_ADDR;
    logic         AERIN_REQ;
    logic         AERIN_ACK;
    logic [M:0]   EVENT_COUNT;
    logic         ENCODER_DONE;

    modport master (
        input  NEW_IMAGE, PIXEL_DATA, PIXEL_VALID, INFERENCE_RDY, AERIN_ACK,
        output PIXEL_READY, AERIN_ADDR, AERIN_REQ, EVENT_COUNT, ENCODER_DONE
    );

    modport slave (
        output NEW_IMAGE, PIXEL_DATA, PIXEL_VALID, INFERENCE_RDY, AERIN_ACK,
        input  PIXEL_READY, AERIN_ADDR, AERIN_REQ, EVENT_COUNT, ENCODER_DONE
    );
endinterface
`default_nettype wire

// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder
// Brief    : Buffers one image and emits it as a rank-order AER spike train.
// Revision : 1.0 - initial release
// ============================================================================
module spike_encoder #(
    parameter int N = 256,
    parameter int M = 8,
    parameter int P = 8
) (
    input  logic             CLK,
    input  logic             RST,
    spike_encoder_if.master  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [M-1:0] LAST_IDX = M'(N - 1);

    logic [2:0]   state_q,   state_d;
    logic [M-1:0] idx_q,     idx_d;
    logic [P-1:0] level_q,   level_d;
    logic [M-1:0] wr_idx_q,  wr_idx_d;
    logic [P-1:0] max_val_q, max_val_d;
    logic [M-1:0] addr_q,    addr_d;
    logic [M:0]   count_q,   count_d;
    logic         ack_meta_q;
    logic         ack_sync_q;

    logic [P-1:0] pix_q [N];

    logic         w_accept;
    logic         w_new;
    logic [P-1:0] w_max;
    logic         w_last_pos;
    logic [M-1:0] w_adv_idx;
    logic [P-1:0] w_adv_level;

    assign w_accept    = (state_q == S_LOAD) && bus.PIXEL_VALID;
    assign w_new       = bus.NEW_IMAGE && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_max       = (bus.PIXEL_DATA > max_val_q) ? bus.PIXEL_DATA : max_val_q;
    assign w_last_pos  = (idx_q == LAST_IDX) && (level_q == P'(1));
    assign w_adv_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign w_adv_level = (idx_q == LAST_IDX) ? level_q - 1'b1 : level_q;

    // State and datapath registers; the synchroniser is the only consumer of AERIN_ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            level_q    <= '0;
            wr_idx_q   <= '0;
            max_val_q  <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            wr_idx_q   <= wr_idx_d;
            max_val_q  <= max_val_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            ack_meta_q <= bus.AERIN_ACK;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Pixel buffer is never cleared; every LOAD overwrites all N entries.
    always_ff @(posedge CLK) begin
        if (!RST && w_accept) begin
            pix_q[wr_idx_q] <= bus.PIXEL_DATA;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        level_d   = level_q;
        wr_idx_d  = wr_idx_q;
        max_val_d = max_val_q;
        addr_d    = addr_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_new) begin
                    state_d   = S_LOAD;
                    wr_idx_d  = '0;
                    max_val_d = '0;
                    count_d   = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    wr_idx_d  = wr_idx_q + 1'b1;
                    max_val_d = w_max;
                    if (wr_idx_q == LAST_IDX) begin
                        if (w_max == '0) begin
                            state_d = S_DONE;
                        end else begin
                            level_d = w_max;
                            idx_d   = '0;
                            state_d = S_SCAN;
                        end
                    end
                end
            end
            S_SCAN: begin
                if (bus.INFERENCE_RDY) begin
                    state_d = S_DONE;
                end else if (pix_q[idx_q] == level_q) begin
                    addr_d  = idx_q;
                    state_d = S_REQ;
                end else if (w_last_pos) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = w_adv_idx;
                    level_d = w_adv_level;
                end
            end
            S_REQ: begin
                if (ack_sync_q) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Stop requests are only honoured once the handshake has fully closed.
                if (!ack_sync_q) begin
                    count_d = count_q + 1'b1;
                    if (bus.INFERENCE_RDY || w_last_pos) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = w_adv_idx;
                        level_d = w_adv_level;
                        state_d = S_SCAN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.PIXEL_READY  = (state_q == S_LOAD);
        bus.AERIN_REQ    = (state_q == S_REQ);
        bus.ENCODER_DONE = (state_q == S_DONE);
        bus.AERIN_ADDR   = addr_q;
        bus.EVENT_COUNT  = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_encoder
// Brief    : Directed self-checking bench for spike_encoder (N=4, M=2, P=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_encoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ack_mode;
    logic ack_man;
    logic [9:0] req_dly;
    logic req_prev;
    logic [1:0] ev_q [$];

    spike_encoder_if #(.M(2), .P(4)) bus ();

    spike_encoder #(.N(4), .M(2), .P(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ack_mode: 0 manual, 1 zero-delay echo of REQ, 2 echo delayed by 10 cycles
    assign bus.AERIN_ACK = (ack_mode == 1) ? bus.AERIN_REQ :
                           (ack_mode == 2) ? req_dly[9] : ack_man;

    initial begin
        req_dly  = '0;
        req_prev = 1'b0;
    end

    always @(posedge clk) begin
        req_dly <= {req_dly[8:0], bus.AERIN_REQ};
        if (bus.AERIN_REQ && !req_prev) ev_q.push_back(bus.AERIN_ADDR);
        req_prev <= bus.AERIN_REQ;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev_at(input int i);
        if (i < ev_q.size()) return 32'(ev_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic pulse_new();
        bus.NEW_IMAGE = 1'b1;
        @(negedge clk);
        bus.NEW_IMAGE = 1'b0;
    endtask

    task automatic load4(input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3, input int ni_at);
        logic [3:0] px [4];
        px = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            bus.PIXEL_DATA  = px[i];
            bus.PIXEL_VALID = 1'b1;
            bus.NEW_IMAGE   = (i == ni_at);
            @(negedge clk);
        end
        bus.PIXEL_VALID = 1'b0;
        bus.NEW_IMAGE   = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!bus.ENCODER_DONE && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (!bus.AERIN_REQ && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ack_mode = 0;
        ack_man  = 1'b0;
        rst = 1'b1;
        bus.NEW_IMAGE     = 1'b0;
        bus.PIXEL_DATA    = '0;
        bus.PIXEL_VALID   = 1'b0;
        bus.INFERENCE_RDY = 1'b0;

        // 1: reset values, then NEW_IMAGE opens LOAD
        repeat (2) @(negedge clk);
        check("rst_ready", bus.PIXEL_READY, 0);
        check("rst_req",   bus.AERIN_REQ, 0);
        check("rst_done",  bus.ENCODER_DONE, 0);
        check("rst_count", bus.EVENT_COUNT, 0);
        check("rst_addr",  bus.AERIN_ADDR, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.PIXEL_READY, 0);
        pulse_new();
        check("load_ready", bus.PIXEL_READY, 1);

        // 2: {3,9,0,9} with zero-delay ACK -> 1, 3, 0
        ack_mode = 1;
        ev_q.delete();
        load4(4'd3, 4'd9, 4'd0, 4'd9, -1);
        check("t2_ready_off", bus.PIXEL_READY, 0);
        wait_done(400);
        check("t2_done",   bus.ENCODER_DONE, 1);
        check("t2_nev",    ev_q.size(), 3);
        check("t2_ev0",    ev_at(0), 1);
        check("t2_ev1",    ev_at(1), 3);
        check("t2_ev2",    ev_at(2), 0);
        check("t2_count",  bus.EVENT_COUNT, 3);
        check("t2_req",    bus.AERIN_REQ, 0);

        // 3: all-zero image goes straight to DONE
        pulse_new();
        check("t3_ready",   bus.PIXEL_READY, 1);
        check("t3_cleared", bus.EVENT_COUNT, 0);
        ev_q.delete();
        load4(4'd0, 4'd0, 4'd0, 4'd0, -1);
        check("t3_done_now", bus.ENCODER_DONE, 1);
        repeat (5) @(negedge clk);
        check("t3_nev",   ev_q.size(), 0);
        check("t3_count", bus.EVENT_COUNT, 0);
        check("t3_done",  bus.ENCODER_DONE, 1);

        // 4: {5,5,5,5}, slow ACK, stop raised during REQ for address 1
        ack_mode = 2;
        pulse_new();
        ev_q.delete();
        load4(4'd5, 4'd5, 4'd5, 4'd5, -1);
        begin
            int n = 0;
            while (!(bus.AERIN_REQ && bus.AERIN_ADDR == 2'd1) && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_req_a1", {bus.AERIN_REQ, bus.AERIN_ADDR}, 3'b101);
        bus.INFERENCE_RDY = 1'b1;
        @(negedge clk);
        check("t4_req_held", bus.AERIN_REQ, 1);
        wait_done(200);
        check("t4_done",  bus.ENCODER_DONE, 1);
        check("t4_count", bus.EVENT_COUNT, 2);
        repeat (20) @(negedge clk);
        check("t4_nev",  ev_q.size(), 2);
        check("t4_ev0",  ev_at(0), 0);
        check("t4_ev1",  ev_at(1), 1);
        bus.INFERENCE_RDY = 1'b0;

        // 5: manual ACK timing; REQ falls three cycles after ACK rises
        ack_mode = 0;
        ack_man  = 1'b0;
        pulse_new();
        ev_q.delete();
        load4(4'd0, 4'd0, 4'd2, 4'd0, -1);
        wait_req(50);
        check("t5_req",  bus.AERIN_REQ, 1);
        check("t5_addr", bus.AERIN_ADDR, 2);
        repeat (2) @(negedge clk);
        check("t5_req_wait", bus.AERIN_REQ, 1);
        ack_man = 1'b1;
        @(negedge clk);
        check("t5_req_a1", bus.AERIN_REQ, 1);
        @(negedge clk);
        check("t5_req_a2", bus.AERIN_REQ, 1);
        check("t5_addr_a2", bus.AERIN_ADDR, 2);
        @(negedge clk);
        check("t5_req_a3", bus.AERIN_REQ, 0);
        check("t5_addr_a3", bus.AERIN_ADDR, 2);
        repeat (2) @(negedge clk);
        check("t5_rel_req",   bus.AERIN_REQ, 0);
        check("t5_rel_count", bus.EVENT_COUNT, 0);
        ack_man = 1'b0;
        @(negedge clk);
        check("t5_f1_addr", bus.AERIN_ADDR, 2);
        @(negedge clk);
        check("t5_f2_addr",  bus.AERIN_ADDR, 2);
        check("t5_f2_count", bus.EVENT_COUNT, 0);
        @(negedge clk);
        check("t5_f3_count", bus.EVENT_COUNT, 1);
        wait_done(100);
        check("t5_done", bus.ENCODER_DONE, 1);
        check("t5_nev",  ev_q.size(), 1);
        check("t5_count_end", bus.EVENT_COUNT, 1);

        // 6: reset in REQ, then {1,0,0,2} with a stray NEW_IMAGE during LOAD
        pulse_new();
        load4(4'd0, 4'd5, 4'd0, 4'd0, -1);
        wait_req(50);
        check("t6_req", bus.AERIN_REQ, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_req",   bus.AERIN_REQ, 0);
        check("t6_rst_ready", bus.PIXEL_READY, 0);
        check("t6_rst_done",  bus.ENCODER_DONE, 0);
        check("t6_rst_count", bus.EVENT_COUNT, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_ready", bus.PIXEL_READY, 0);
        pulse_new();
        check("t6_load_ready", bus.PIXEL_READY, 1);
        ack_mode = 1;
        ev_q.delete();
        load4(4'd1, 4'd0, 4'd0, 4'd2, 1);
        wait_done(200);
        check("t6_done",  bus.ENCODER_DONE, 1);
        check("t6_nev",   ev_q.size(), 2);
        check("t6_ev0",   ev_at(0), 3);
        check("t6_ev1",   ev_at(1), 0);
        check("t6_count", bus.EVENT_COUNT, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
